// File: rtl/trap_ctrl.sv
// trap_ctrl: sequences machine-mode trap entry and MRET return over the CSR port.
// Ports: clk/rst; exc_i, exc_code_i, irq_i, irq_en_i, mret_i, pc_i, tval_i requests;
//   csr_w/csr_addr/csr_wd/csr_rd CSR port; stall_o, pc_redirect_o, pc_target_o, busy_o.
module trap_ctrl #(
  parameter logic [11:0] MTVEC_ADDR  = 12'h005,
  parameter logic [11:0] MEPC_ADDR   = 12'h041,
  parameter logic [11:0] MCAUSE_ADDR = 12'h042,
  parameter logic [11:0] MTVAL_ADDR  = 12'h043
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_i,
  input  logic [4:0]  exc_code_i,
  input  logic        irq_i,
  input  logic        irq_en_i,
  input  logic        mret_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] tval_i,
  output logic        csr_w,
  output logic [11:0] csr_addr,
  output logic [31:0] csr_wd,
  input  logic [31:0] csr_rd,
  output logic        stall_o,
  output logic        pc_redirect_o,
  output logic [31:0] pc_target_o,
  output logic        busy_o
);

  typedef enum logic [2:0] {
    IDLE,
    W_MEPC,
    W_MCAUSE,
    W_MTVAL,
    R_MTVEC,
    R_MEPC,
    REDIRECT
  } state_t;

  localparam logic [31:0] IRQ_CAUSE = 32'h8000_000B;

  state_t      state;
  state_t      state_nx;

  logic [31:0] pc_q;
  logic [31:0] tval_q;
  logic [31:0] cause_q;
  logic [31:0] target_q;

  logic        irq_req;
  logic        take_exc;
  logic        take_irq;
  logic        take_mret;
  logic        idle;
  logic        accept;

  // Mutually exclusive takes encode the exc > irq > mret priority.
  assign irq_req   = irq_i & irq_en_i;
  assign idle      = (state == IDLE);
  assign take_exc  = idle & exc_i;
  assign take_irq  = idle & ~exc_i & irq_req;
  assign take_mret = idle & ~exc_i & ~irq_req & mret_i;
  assign accept    = take_exc | take_irq | take_mret;

  assign busy_o        = ~idle;
  // Gate with rst so a request seen during reset never freezes the pipe.
  assign stall_o       = busy_o | (accept & ~rst);
  assign pc_redirect_o = (state == REDIRECT);
  assign pc_target_o   = target_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        unique case (1'b1)
          take_exc:  state_nx = W_MEPC;
          take_irq:  state_nx = W_MEPC;
          take_mret: state_nx = R_MEPC;
          default:   state_nx = IDLE;
        endcase
      end
      W_MEPC:   state_nx = W_MCAUSE;
      W_MCAUSE: state_nx = W_MTVAL;
      W_MTVAL:  state_nx = R_MTVEC;
      R_MTVEC:  state_nx = REDIRECT;
      R_MEPC:   state_nx = REDIRECT;
      REDIRECT: state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_comb begin
    csr_w    = 1'b0;
    csr_addr = 12'h000;
    csr_wd   = 32'h0;
    unique case (state)
      W_MEPC: begin
        csr_w    = 1'b1;
        csr_addr = MEPC_ADDR;
        csr_wd   = {pc_q[31:2], 2'b00};
      end
      W_MCAUSE: begin
        csr_w    = 1'b1;
        csr_addr = MCAUSE_ADDR;
        csr_wd   = cause_q;
      end
      W_MTVAL: begin
        csr_w    = 1'b1;
        csr_addr = MTVAL_ADDR;
        csr_wd   = tval_q;
      end
      R_MTVEC: csr_addr = MTVEC_ADDR;
      R_MEPC:  csr_addr = MEPC_ADDR;
      default: begin
        csr_w    = 1'b0;
        csr_addr = 12'h000;
        csr_wd   = 32'h0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= 32'h0;
      tval_q  <= 32'h0;
      cause_q <= 32'h0;
    end else begin
      unique case (1'b1)
        take_exc: begin
          pc_q    <= pc_i;
          tval_q  <= tval_i;
          cause_q <= {27'b0, exc_code_i};
        end
        take_irq: begin
          pc_q    <= pc_i;
          tval_q  <= 32'h0;
          cause_q <= IRQ_CAUSE;
        end
        take_mret: begin
          pc_q    <= pc_i;
          tval_q  <= tval_i;
          cause_q <= cause_q;
        end
        default: begin
          pc_q    <= pc_q;
          tval_q  <= tval_q;
          cause_q <= cause_q;
        end
      endcase
    end
  end

  // Only direct-mode mtvec is supported, so the mode bits are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target_q <= 32'h0;
    end else if (state == R_MTVEC) begin
      target_q <= {csr_rd[31:2], 2'b00};
    end else if (state == R_MEPC) begin
      target_q <= csr_rd;
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: scoreboard bench for trap_ctrl with a small CSR-file model.
// Expected CSR writes and redirects are queued at stimulus time.
module tb_trap_ctrl;

  localparam logic [11:0] A_MTVEC  = 12'h005;
  localparam logic [11:0] A_MEPC   = 12'h041;
  localparam logic [11:0] A_MCAUSE = 12'h042;
  localparam logic [11:0] A_MTVAL  = 12'h043;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        exc_i = 1'b0;
  logic [4:0]  exc_code_i = 5'd0;
  logic        irq_i = 1'b0;
  logic        irq_en_i = 1'b0;
  logic        mret_i = 1'b0;
  logic [31:0] pc_i = 32'h0;
  logic [31:0] tval_i = 32'h0;
  logic        csr_w;
  logic [11:0] csr_addr;
  logic [31:0] csr_wd;
  logic [31:0] csr_rd;
  logic        stall_o;
  logic        pc_redirect_o;
  logic [31:0] pc_target_o;
  logic        busy_o;

  trap_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .exc_i         (exc_i),
    .exc_code_i    (exc_code_i),
    .irq_i         (irq_i),
    .irq_en_i      (irq_en_i),
    .mret_i        (mret_i),
    .pc_i          (pc_i),
    .tval_i        (tval_i),
    .csr_w         (csr_w),
    .csr_addr      (csr_addr),
    .csr_wd        (csr_wd),
    .csr_rd        (csr_rd),
    .stall_o       (stall_o),
    .pc_redirect_o (pc_redirect_o),
    .pc_target_o   (pc_target_o),
    .busy_o        (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] a;
    logic [31:0] d;
    int          c;
  } wr_t;

  typedef struct {
    logic [31:0] t;
    int          c;
  } rd_t;

  wr_t wq[$];
  rd_t rq[$];

  int n_pass = 0;
  int n_tot  = 0;
  int cyc    = 0;
  int n;

  logic [31:0] mtvec_m = 32'h0000_0100;
  logic [31:0] mepc_m  = 32'h0;
  logic [31:0] mcau_m  = 32'h0;
  logic [31:0] mtval_m = 32'h0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      $display("FAIL %s got=%h exp=%h t=%0t",
               tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    csr_rd = 32'h0;
    case (csr_addr)
      A_MTVEC:  csr_rd = mtvec_m;
      A_MEPC:   csr_rd = mepc_m;
      A_MCAUSE: csr_rd = mcau_m;
      A_MTVAL:  csr_rd = mtval_m;
      default:  csr_rd = 32'h0;
    endcase
  end

  always @(negedge clk) begin
    if (csr_w) begin
      chk("wr_expected", 32'(wq.size() != 0), 32'd1);
      if (wq.size() != 0) begin
        wr_t e;
        e = wq.pop_front();
        chk("wr_addr", {20'h0, csr_addr}, {20'h0, e.a});
        chk("wr_data", csr_wd, e.d);
        chk("wr_cyc", cyc, e.c);
      end
      case (csr_addr)
        A_MEPC:   mepc_m  <= csr_wd;
        A_MCAUSE: mcau_m  <= csr_wd;
        A_MTVAL:  mtval_m <= csr_wd;
        default: ;
      endcase
    end
    if (pc_redirect_o) begin
      chk("rd_expected", 32'(rq.size() != 0), 32'd1);
      if (rq.size() != 0) begin
        rd_t r;
        r = rq.pop_front();
        chk("rd_target", pc_target_o, r.t);
        chk("rd_cyc", cyc, r.c);
      end
    end
  end

  task automatic exp_trap(input int c0,
                          input logic [31:0] epc,
                          input logic [31:0] cau,
                          input logic [31:0] tv,
                          input logic [31:0] tgt);
    wq.push_back('{A_MEPC, epc, c0 + 1});
    wq.push_back('{A_MCAUSE, cau, c0 + 2});
    wq.push_back('{A_MTVAL, tv, c0 + 3});
    rq.push_back('{tgt, c0 + 5});
  endtask

  task automatic fire(input logic e,
                      input logic [4:0] code,
                      input logic i,
                      input logic en,
                      input logic m,
                      input logic [31:0] pc,
                      input logic [31:0] tv,
                      input logic exp_stall,
                      output int c0);
    @(posedge clk);
    #1;
    exc_i = e;
    exc_code_i = code;
    irq_i = i;
    irq_en_i = en;
    mret_i = m;
    pc_i = pc;
    tval_i = tv;
    c0 = cyc;
    #1;
    chk("stall_acc", {31'h0, stall_o}, {31'h0, exp_stall});
    chk("busy_pre", {31'h0, busy_o}, 32'h0);
    @(posedge clk);
    #1;
    exc_i = 1'b0;
    irq_i = 1'b0;
    irq_en_i = 1'b0;
    mret_i = 1'b0;
    tval_i = 32'h0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40; i++) begin
      if (wq.size() == 0 && rq.size() == 0) break;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    chk(tag, 32'(wq.size() + rq.size()), 32'h0);
    chk("busy_idle", {31'h0, busy_o}, 32'h0);
  endtask

  initial begin
    exc_i = 1'b1;
    irq_i = 1'b1;
    irq_en_i = 1'b1;
    #3;
    chk("rst_csr_w", {31'h0, csr_w}, 32'h0);
    chk("rst_addr", {20'h0, csr_addr}, 32'h0);
    chk("rst_wd", csr_wd, 32'h0);
    chk("rst_stall", {31'h0, stall_o}, 32'h0);
    chk("rst_busy", {31'h0, busy_o}, 32'h0);
    chk("rst_redir", {31'h0, pc_redirect_o}, 32'h0);
    chk("rst_tgt", pc_target_o, 32'h0);
    exc_i = 1'b0;
    irq_i = 1'b0;
    irq_en_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    chk("post_rst_busy", {31'h0, busy_o}, 32'h0);

    // Basic exception into mtvec 0x100.
    fire(1, 5'd2, 0, 0, 0, 32'h18, 32'h0050_2073, 1, n);
    exp_trap(n, 32'h18, 32'h2, 32'h0050_2073, 32'h100);
    @(negedge clk);
    chk("busy_seq", {31'h0, busy_o}, 32'h1);
    chk("stall_seq", {31'h0, stall_o}, 32'h1);
    drain("exc_drain");

    // Masked interrupt does nothing.
    fire(0, 5'd0, 1, 0, 0, 32'h40, 32'h0, 0, n);
    drain("irq_off_drain");

    // Enabled interrupt; a mret pulse while busy is ignored.
    fire(0, 5'd0, 1, 1, 0, 32'h40, 32'hDEAD_BEEF, 1, n);
    exp_trap(n, 32'h40, 32'h8000_000B, 32'h0, 32'h100);
    mret_i = 1'b1;
    @(posedge clk);
    #1 mret_i = 1'b0;
    drain("irq_drain");

    // All requests together; unaligned pc and mtvec mode bits dropped.
    mtvec_m = 32'h0000_0203;
    fire(1, 5'd5, 1, 1, 1, 32'h1E, 32'h77, 1, n);
    exp_trap(n, 32'h1C, 32'h5, 32'h77, 32'h200);
    drain("prio_drain");

    // Trap at 0x27 leaves mepc=0x24, then MRET returns there.
    fire(1, 5'd0, 0, 0, 0, 32'h27, 32'h0, 1, n);
    exp_trap(n, 32'h24, 32'h0, 32'h0, 32'h200);
    drain("pre_mret_drain");
    fire(0, 5'd0, 0, 0, 1, 32'h99, 32'h0, 1, n);
    rq.push_back('{32'h24, n + 2});
    drain("mret_drain");
    repeat (3) @(negedge clk);
    chk("tgt_hold", pc_target_o, 32'h24);

    // Reset in W_MCAUSE aborts the sequence.
    fire(1, 5'd7, 0, 0, 0, 32'h60, 32'h5, 1, n);
    wq.push_back('{A_MEPC, 32'h60, n + 1});
    @(posedge clk);
    #2;
    chk("mcause_live", {31'h0, csr_w}, 32'h1);
    rst = 1'b1;
    #1;
    chk("abort_csr_w", {31'h0, csr_w}, 32'h0);
    chk("abort_busy", {31'h0, busy_o}, 32'h0);
    chk("abort_tgt", pc_target_o, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(negedge clk);
    drain("abort_drain");

    // Held exception: one sequence, next accept right after REDIRECT.
    @(posedge clk);
    #1;
    exc_i = 1'b1;
    exc_code_i = 5'd3;
    pc_i = 32'h80;
    tval_i = 32'h11;
    n = cyc;
    exp_trap(n, 32'h80, 32'h3, 32'h11, 32'h200);
    exp_trap(n + 6, 32'h80, 32'h3, 32'h11, 32'h200);
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("gap_busy", {31'h0, busy_o}, 32'h0);
    chk("gap_stall", {31'h0, stall_o}, 32'h1);
    @(posedge clk);
    #1 exc_i = 1'b0;
    drain("hold_drain");

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
- MTVEC_ADDR, 12'h005, CSR index of mtvec
- MEPC_ADDR, 12'h041, CSR index of mepc
- MCAUSE_ADDR, 12'h042, CSR index of mcause
- MTVAL_ADDR, 12'h043, CSR index of mtval
REQ-002 SHALL have ports, one per line: name, direction, width, meaning.
- clk, in, 1, sole clock, rising edge
- rst, in, 1, asynchronous active-high reset
- exc_i, in, 1, synchronous exception request from decode/execute
- exc_code_i, in, 5, exception code
- irq_i, in, 1, external interrupt, level
- irq_en_i, in, 1, global interrupt enable (mstatus.MIE)
- mret_i, in, 1, MRET instruction in execute
- pc_i, in, 32, PC of faulting/interrupted instruction
- tval_i, in, 32, faulting address/instruction
- csr_w, out, 1, CSR write enable to CSR block
- csr_addr, out, 12, CSR index to CSR block
- csr_wd, out, 32, CSR write data
- csr_rd, in, 32, combinational CSR read data for csr_addr
- stall_o, out, 1, freeze pipeline
- pc_redirect_o, out, 1, one-cycle PC load strobe
- pc_target_o, out, 32, PC load value
- busy_o, out, 1, FSM not in IDLE

Function
REQ-003 SHALL implement states IDLE, W_MEPC, W_MCAUSE, W_MTVAL, R_MTVEC, R_MEPC, REDIRECT.
REQ-004 In IDLE, priority SHALL be exc_i > (irq_i & irq_en_i) > mret_i; the winner is accepted on that rising edge.
REQ-005 On accept, SHALL latch pc_i, tval_i and cause: exception -> {27'b0, exc_code_i}; interrupt -> 32'h8000_000B with tval latched as 0.
REQ-006 Trap path SHALL be IDLE -> W_MEPC -> W_MCAUSE -> W_MTVAL -> R_MTVEC -> REDIRECT -> IDLE, one cycle per state.
REQ-007 W_MEPC SHALL drive csr_w=1, csr_addr=MEPC_ADDR, csr_wd={pc[31:2],2'b00}.
REQ-008 W_MCAUSE SHALL drive csr_w=1, csr_addr=MCAUSE_ADDR, csr_wd=latched cause.
REQ-009 W_MTVAL SHALL drive csr_w=1, csr_addr=MTVAL_ADDR, csr_wd=latched tval.
REQ-010 R_MTVEC SHALL drive csr_w=0, csr_addr=MTVEC_ADDR and register target={csr_rd[31:2],2'b00} (direct mode only).
REQ-011 MRET path SHALL be IDLE -> R_MEPC -> REDIRECT -> IDLE; R_MEPC drives csr_w=0, csr_addr=MEPC_ADDR and registers target=csr_rd.
REQ-012 REDIRECT SHALL assert pc_redirect_o=1 for exactly one cycle with pc_target_o=registered target.
REQ-013 pc_target_o SHALL hold its last value until the next REDIRECT.
REQ-014 csr_w SHALL be 0 and csr_addr/csr_wd 0 in all states other than the three write states and the two read states (read states drive csr_wd=0).
REQ-015 stall_o SHALL equal (state != IDLE) OR (an accept condition in IDLE), combinationally.
REQ-016 busy_o SHALL equal (state != IDLE).
REQ-017 Requests arriving while not in IDLE SHALL be ignored; no queueing.
REQ-018 Trap latency SHALL be 5 cycles accept-to-redirect; MRET latency 2 cycles.

Reset
REQ-019 rst high SHALL immediately force IDLE; csr_w, pc_redirect_o, stall_o, busy_o=0; csr_addr, csr_wd, pc_target_o, latches=0.
REQ-020 rst asserted mid-sequence SHALL abort it with no further CSR writes after release; first post-reset action requires a fresh request.

Verification
REQ-021 exc_i=1, exc_code_i=2, pc_i=0x18, tval_i=0x00502073, mtvec=0x100 -> writes mepc=0x18, mcause=0x2, mtval=0x00502073 on cycles 1-3; redirect to 0x100 on cycle 5.
REQ-022 irq_i=1, irq_en_i=1, pc_i=0x40 -> mcause=0x8000000B, mtval=0, mepc=0x40; irq_i with irq_en_i=0 -> no action, stall_o=0.
REQ-023 exc_i, irq_i/irq_en_i, mret_i all high same cycle -> exception path taken, mcause=exc code.
REQ-024 mret_i=1 with mepc=0x24 -> no CSR writes, pc_redirect_o=1 with pc_target_o=0x24 two cycles after accept.
REQ-025 rst pulsed during W_MCAUSE -> csr_w drops asynchronously, mtval never written, no redirect, state IDLE.
REQ-026 exc_i held high across a trap sequence -> exactly one sequence during busy; a new one begins only on the cycle after REDIRECT when exc_i is still high.
